// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Holds the frame FSM encoding and the frame-length helpers.
package fifo_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   localparam int DATA_BITS = 8;

   // start bit + data bits + stop bit, parity excluded
   localparam int FRAME_BITS = DATA_BITS + 2;

   function automatic int frame_cycles(input int cpb, input int par);
      return (FRAME_BITS + par) * cpb;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Held at zero while restart is high so each frame starts aligned.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic clear_i,
   input  logic restart_i,
   output logic tick_o
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = !restart_i && (cnt_q == LAST);

   // Next count: wrap at end of bit, hold at zero on restart
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart_i || tick_o) begin
         cnt_d = '0;
      end
   end

   // Counter register with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!clear_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream FIFO.
// One read strobe per frame; frames run back-to-back while data waits.
module fifo_uart_tx
   import fifo_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   input  logic       fifo_data_valid,
   output logic       fifo_rd,
   output logic       txd,
   output logic       busy
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   state_t     state_q, state_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic       txd_q, txd_d;
   logic       tick;
   logic       restart;

   assign restart = !(state_q inside {S_START, S_DATA, S_PAR, S_STOP});

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .clear_i  (clear),
      .restart_i(restart),
      .tick_o   (tick)
   );

   // State, bit index, captured byte and line register
   always_ff @(posedge clk) begin
      if (!clear) begin
         state_q <= S_IDLE;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

   // Frame sequencing; byte captured when the FIFO answers
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      unique case (state_q)
         S_IDLE: begin
            if (enable && !fifo_empty) state_d = S_REQ;
         end
         S_REQ: begin
            // FIFO drained under us: abandon rather than wait forever
            state_d = fifo_empty ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (fifo_data_valid) begin
               shift_d = fifo_data;
               bit_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) state_d = S_DATA;
         end
         S_DATA: begin
            if (tick) begin
               if (bit_q == LAST_BIT) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_PAR: begin
            if (tick) state_d = S_STOP;
         end
         S_STOP: begin
            if (tick) begin
               state_d = (enable && !fifo_empty) ? S_REQ : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Line level for the upcoming cycle, plus strobe and busy
   always_comb begin
      txd_d = 1'b1;
      unique case (state_d)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shift_d[bit_d];
         S_PAR:   txd_d = ^shift_d;
         default: txd_d = 1'b1;
      endcase
      fifo_rd = (state_q == S_REQ) && !fifo_empty;
      busy    = (state_q != S_IDLE);
   end

   assign txd = txd_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity),
// each fed by a small FIFO model, frames checked cycle by cycle.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic clk = 1'b0;
   logic clear = 1'b0;
   logic enable = 1'b0;

   logic       empty0, valid0 = 1'b0, rd0, txd0, busy0;
   logic       empty1, valid1 = 1'b0, rd1, txd1, busy1;
   logic [7:0] data0 = '0, data1 = '0;
   logic [7:0] mem0 [64];
   logic [7:0] mem1 [64];
   int wr0 = 0, rdp0 = 0, wr1 = 0, rdp1 = 0;

   int cyc = 0;
   int checks = 0, errors = 0;
   int rdcnt0 = 0, rdcnt1 = 0, last_rd0 = 0, last_rd1 = 0;
   int bcnt0 = 0, bcnt1 = 0, last_end = 0;

   always #5 clk = ~clk;

   assign empty0 = (wr0 == rdp0);
   assign empty1 = (wr1 == rdp1);

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
      .clk(clk), .clear(clear), .enable(enable),
      .fifo_empty(empty0), .fifo_data(data0),
      .fifo_data_valid(valid0), .fifo_rd(rd0),
      .txd(txd0), .busy(busy0)
   );

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
      .clk(clk), .clear(clear), .enable(enable),
      .fifo_empty(empty1), .fifo_data(data1),
      .fifo_data_valid(valid1), .fifo_rd(rd1),
      .txd(txd1), .busy(busy1)
   );

   // FIFO models: answer a read one cycle later, junk otherwise
   always @(posedge clk) begin
      cyc++;
      if (rd0 && !empty0) begin
         data0 <= mem0[rdp0];
         valid0 <= 1'b1;
         rdp0 <= rdp0 + 1;
      end else begin
         data0 <= 8'($urandom);
         valid0 <= 1'b0;
      end
      if (rd1 && !empty1) begin
         data1 <= mem1[rdp1];
         valid1 <= 1'b1;
         rdp1 <= rdp1 + 1;
      end else begin
         data1 <= 8'($urandom);
         valid1 <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Strobe counting and FIFO protocol watch
   always @(negedge clk) begin
      if (rd0 === 1'b1) begin rdcnt0++; last_rd0 = cyc; end
      if (rd1 === 1'b1) begin rdcnt1++; last_rd1 = cyc; end
      if (busy0 === 1'b1) bcnt0++;
      if (busy1 === 1'b1) bcnt1++;
      chk("rd_while_empty0", 32'(rd0 & empty0), 0);
      chk("rd_while_empty1", 32'(rd1 & empty1), 0);
   end

   function automatic logic txd_of(input int s);
      return (s == 1) ? txd1 : txd0;
   endfunction

   function automatic logic busy_of(input int s);
      return (s == 1) ? busy1 : busy0;
   endfunction

   task automatic push(input int s, input logic [7:0] b);
      if (s == 1) begin mem1[wr1] = b; wr1++; end
      else begin mem0[wr0] = b; wr0++; end
   endtask

   // Reference frame: start, data LSB first, [even parity], stop
   task automatic check_frame(input int s, input logic [7:0] b,
                              input bit b2b);
      int t;
      int nb;
      int ones;
      int st;
      logic bits [11];
      t = 0;
      while (txd_of(s) !== 1'b0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("start_seen", 32'(t < 400), 1);
      if (t >= 400) return;
      st = cyc;
      chk("rd_to_start", st - ((s == 1) ? last_rd1 : last_rd0), 2);
      if (b2b) chk("b2b_gap", st - last_end, 2);
      nb = (s == 1) ? 11 : 10;
      ones = 0;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bits[i+1] = b[i];
         ones += int'(b[i]);
      end
      if (s == 1) bits[9] = (ones % 2 == 1);
      bits[nb-1] = 1'b1;
      for (int i = 0; i < nb; i++) begin
         for (int j = 0; j < CPB; j++) begin
            chk($sformatf("txd_bit%0d_b%02h", i, b),
                32'(txd_of(s)), 32'(bits[i]));
            chk("busy_in_frame", 32'(busy_of(s)), 1);
            @(negedge clk);
         end
      end
      last_end = cyc;
   endtask

   initial begin
      int rb, bb, t;
      logic [7:0] rnd [6];

      repeat (3) @(negedge clk);
      chk("reset_state", {26'd0, txd0, busy0, rd0, txd1, busy1, rd1},
          32'b100100);
      clear = 1'b1;
      enable = 1'b1;

      // Empty FIFO: line idles, no strobes
      repeat (100) begin
         @(negedge clk);
         chk("idle_empty", {26'd0, txd0, busy0, rd0, txd1, busy1, rd1},
             32'b100100);
      end

      // Single byte, no parity
      rb = rdcnt0; bb = bcnt0;
      push(0, 8'hA5);
      check_frame(0, 8'hA5, 1'b0);
      chk("busy_after_A5", 32'(busy0), 0);
      @(negedge clk);
      chk("rd_pulses_A5", rdcnt0 - rb, 1);
      chk("busy_cycles_A5", bcnt0 - bb, 2 + 10 * CPB);

      // Single byte, even parity
      rb = rdcnt1; bb = bcnt1;
      push(1, 8'h07);
      check_frame(1, 8'h07, 1'b0);
      @(negedge clk);
      chk("rd_pulses_07", rdcnt1 - rb, 1);
      chk("busy_cycles_07", bcnt1 - bb, 2 + 11 * CPB);

      // Three queued bytes back-to-back
      rb = rdcnt0;
      push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
      check_frame(0, 8'h01, 1'b0);
      check_frame(0, 8'h02, 1'b1);
      check_frame(0, 8'h03, 1'b1);
      repeat (5) @(negedge clk);
      chk("rd_pulses_3", rdcnt0 - rb, 3);
      chk("busy_after_3", 32'(busy0), 0);

      // Random bytes on both instances
      for (int i = 0; i < 6; i++) rnd[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) push(0, rnd[i]);
      for (int i = 0; i < 6; i++) check_frame(0, rnd[i], i > 0);
      for (int i = 0; i < 4; i++) rnd[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) push(1, rnd[i]);
      for (int i = 0; i < 4; i++) check_frame(1, rnd[i], i > 0);
      repeat (3) @(negedge clk);

      // Enable dropped mid-data: frame completes, nothing follows
      rb = rdcnt0;
      push(0, 8'hFF); push(0, 8'h11); push(0, 8'h22);
      fork
         check_frame(0, 8'hFF, 1'b0);
         begin
            t = 0;
            while (txd0 !== 1'b0 && t < 400) begin
               @(negedge clk);
               t++;
            end
            repeat (3 * CPB) @(negedge clk);
            enable = 1'b0;
         end
      join
      chk("busy_after_FF", 32'(busy0), 0);
      repeat (30) begin
         @(negedge clk);
         chk("line_idle_disabled", {30'd0, txd0, busy0}, 32'b10);
      end
      chk("rd_pulses_FF", rdcnt0 - rb, 1);
      enable = 1'b1;
      check_frame(0, 8'h11, 1'b0);
      check_frame(0, 8'h22, 1'b1);
      repeat (3) @(negedge clk);

      // Reset during data bit 3 of 8'h55
      push(0, 8'h55); push(0, 8'h3C);
      t = 0;
      while (txd0 !== 1'b0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("start_55", 32'(t < 400), 1);
      repeat (4 * CPB) @(negedge clk);
      chk("bit3_of_55", 32'(txd0), 0);
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      chk("abort_line", {29'd0, txd0, busy0, rd0}, 32'b100);
      @(negedge clk);
      clear = 1'b1;
      check_frame(0, 8'h3C, 1'b0);
      repeat (3) @(negedge clk);
      chk("busy_after_3C", 32'(busy0), 0);

      // Reset while strobing: strobe drops, none after release
      push(0, 8'h77);
      t = 0;
      while (rd0 !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("rd_seen_77", 32'(t < 50), 1);
      clear = 1'b0;
      @(negedge clk);
      chk("rd_drop_on_clear", 32'(rd0), 0);
      rb = rdcnt0;
      repeat (2) @(negedge clk);
      clear = 1'b1;
      repeat (20) @(negedge clk);
      chk("no_strobe_after", rdcnt0 - rb, 0);
      chk("idle_after_clear", {30'd0, txd0, busy0}, 32'b10);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
